// File: rtl/instr_dispatch.sv
// instr_dispatch: in-order issue queue that decodes 4-bit opcodes and routes them to memory/FMA and frame-buffer units.
// Defining DISPATCH_PERF_COUNTERS_EN adds the saturating stall_cycles_out counter.
module instr_dispatch #(
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int QUEUE_DEPTH       = 4,
    parameter int FENCE_TIMEOUT     = 1023
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic [INSTRUCTION_WIDTH-1:0] instr_in,
    input  logic                         instr_valid_in,
    output logic                         instr_ready_out,
    output logic [INSTRUCTION_WIDTH-1:0] mem_instr_out,
    output logic                         mem_valid_out,
    input  logic                         mem_ready_in,
    input  logic                         mem_busy_in,
    output logic [INSTRUCTION_WIDTH-1:0] fb_instr_out,
    output logic                         fb_valid_out,
    input  logic                         fb_ready_in,
    output logic [$clog2(QUEUE_DEPTH):0] occupancy_out,
    output logic                         done_out,
    output logic                         timeout_out
`ifdef DISPATCH_PERF_COUNTERS_EN
    ,
    output logic [31:0]                  stall_cycles_out
`endif
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = (FENCE_TIMEOUT > 0) ? $clog2(FENCE_TIMEOUT + 1) : 1;
    localparam logic [PW:0]   DEPTH  = (PW+1)'(QUEUE_DEPTH);
    localparam logic [CW-1:0] FT_MAX = CW'(FENCE_TIMEOUT);

    typedef enum logic [1:0] {RUN, FENCE, DRAIN, DONE} state_t;
    typedef enum logic [1:0] {C_LOCAL, C_MEM, C_FB, C_END} class_t;

    state_t                         state_q, state_d;
    logic [INSTRUCTION_WIDTH-1:0]   fifo_q [QUEUE_DEPTH];
    logic [PW-1:0]                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]                    count_q, count_d;
    logic                           ready_q, ready_d;
    logic [INSTRUCTION_WIDTH-1:0]   mem_instr_q, mem_instr_d, fb_instr_q, fb_instr_d;
    logic                           mem_valid_q, mem_valid_d, fb_valid_q, fb_valid_d;
    logic [CW-1:0]                  fence_cnt_q, fence_cnt_d;
    logic                           timeout_q, timeout_d, done_q, done_d;
    logic [INSTRUCTION_WIDTH-1:0]   head;
    logic [3:0]                     opcode;
    class_t                         cls;
    logic                           push, pop;

    assign head   = fifo_q[rd_ptr_q];
    assign opcode = head[INSTRUCTION_WIDTH-1 -: 4];
    assign push   = instr_valid_in && ready_q;

    always_comb begin
        cls = (opcode == 4'b0001) ? C_END :
              (opcode == 4'b1100) ? C_FB :
              ((opcode >= 4'b0110 && opcode <= 4'b1011) || opcode == 4'b1101 || opcode == 4'b1110) ? C_MEM :
              C_LOCAL;
    end

    // Output registers hold until accepted; a pop only refills a register that is empty or draining this cycle.
    always_comb begin
        state_d     = state_q;
        mem_instr_d = mem_instr_q;
        mem_valid_d = mem_valid_q && !mem_ready_in;
        fb_instr_d  = fb_instr_q;
        fb_valid_d  = fb_valid_q && !fb_ready_in;
        fence_cnt_d = '0;
        pop         = 1'b0;
        case (state_q)
            RUN: begin
                if (count_q != '0) begin
                    if (cls == C_MEM) begin
                        if (!mem_valid_q || mem_ready_in) begin
                            pop         = 1'b1;
                            mem_instr_d = head;
                            mem_valid_d = 1'b1;
                        end
                    end else if (cls == C_FB) begin
                        state_d = FENCE;
                    end else if (cls == C_END) begin
                        pop     = 1'b1;
                        state_d = DRAIN;
                    end else begin
                        pop = 1'b1;
                    end
                end
            end
            FENCE: begin
                fence_cnt_d = (fence_cnt_q == FT_MAX) ? fence_cnt_q : fence_cnt_q + 1'b1;
                if (!mem_valid_q && !mem_busy_in && (!fb_valid_q || fb_ready_in)) begin
                    pop         = 1'b1;
                    fb_instr_d  = head;
                    fb_valid_d  = 1'b1;
                    state_d     = RUN;
                    fence_cnt_d = '0;
                end
            end
            DRAIN: begin
                if (!mem_valid_q && !fb_valid_q && !mem_busy_in) state_d = DONE;
            end
            default: ;
        endcase
    end

    always_comb begin
        count_d   = count_q + (PW+1)'(push) - (PW+1)'(pop);
        wr_ptr_d  = wr_ptr_q + PW'(push);
        rd_ptr_d  = rd_ptr_q + PW'(pop);
        ready_d   = (count_d < DEPTH) && state_d != DONE;
        done_d    = state_d == DONE;
        timeout_d = (FENCE_TIMEOUT != 0) && state_q == FENCE && fence_cnt_q != FT_MAX && fence_cnt_d == FT_MAX;
    end

    always_ff @(posedge clk_in) begin
        if (push) fifo_q[wr_ptr_q] <= instr_in;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= RUN;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ready_q     <= 1'b0;
            mem_instr_q <= '0;
            mem_valid_q <= 1'b0;
            fb_instr_q  <= '0;
            fb_valid_q  <= 1'b0;
            fence_cnt_q <= '0;
            timeout_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ready_q     <= ready_d;
            mem_instr_q <= mem_instr_d;
            mem_valid_q <= mem_valid_d;
            fb_instr_q  <= fb_instr_d;
            fb_valid_q  <= fb_valid_d;
            fence_cnt_q <= fence_cnt_d;
            timeout_q   <= timeout_d;
            done_q      <= done_d;
        end
    end

    assign instr_ready_out = ready_q;
    assign mem_instr_out   = mem_instr_q;
    assign mem_valid_out   = mem_valid_q;
    assign fb_instr_out    = fb_instr_q;
    assign fb_valid_out    = fb_valid_q;
    assign occupancy_out   = count_q;
    assign done_out        = done_q;
    assign timeout_out     = timeout_q;

`ifdef DISPATCH_PERF_COUNTERS_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = (&stall_q) ? stall_q : stall_q + 32'((instr_valid_in && !ready_q) || state_q == FENCE);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) stall_q <= '0;
        else         stall_q <= stall_d;
    end

    assign stall_cycles_out = stall_q;
`endif
endmodule
